// File: rtl/au_dec_timer.sv
// rtl/au_dec_timer.sv - programmable down-counting timer around the au_dec decrementer
// One-shot / auto-reload countdown with prescaled ticks, tc pulse and held completion handshake.

module au_dec #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);
  generate
    if (ARCH == 0) begin : g_sub
      assign y = a - WIDTH'(1);
    end else begin : g_borrow
      // Explicit borrow ripple: bit i flips while every lower bit is zero.
      logic [WIDTH-1:0] brw;
      always_comb begin
        brw    = '0;
        brw[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
          brw[i] = brw[i-1] & ~a[i-1];
        end
        y = a ^ brw;
      end
    end
  endgenerate
endmodule

module au_dec_timer #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_mode,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             tc,
  output logic             done_valid,
  input  logic             done_ready
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] cnt_nx, rld, rld_nx, dec;
  logic             mode, mode_nx, tc_nx, tick;

  au_dec #(.WIDTH(WIDTH), .ARCH(ARCH)) u_dec (.a(cnt), .y(dec));

  generate
    if (DIV == 1) begin : g_nodiv
      assign tick = en;
    end else begin : g_div
      localparam int PW = $clog2(DIV);
      logic [PW-1:0] pre;
      logic          ld_fire;
      assign ld_fire = (state == IDLE) && ld_valid && !abort;
      assign tick    = en && (pre == PW'(DIV - 1));
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          pre <= '0;
        else if (abort || ld_fire)
          pre <= '0;
        else if (state == RUN && en)
          pre <= tick ? '0 : pre + 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rld   <= '0;
      mode  <= 1'b0;
      tc    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      rld   <= rld_nx;
      mode  <= mode_nx;
      tc    <= tc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rld_nx   = rld;
    mode_nx  = mode;
    tc_nx    = 1'b0;
    if (abort) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: if (ld_valid) begin
          cnt_nx  = ld_data;
          rld_nx  = ld_data;
          mode_nx = ld_mode;
          // A zero start value is an immediate terminal event in either mode.
          if (ld_data == '0) begin
            state_nx = DONE;
            tc_nx    = 1'b1;
          end else begin
            state_nx = RUN;
          end
        end
        RUN: if (tick) begin
          if (cnt > WIDTH'(1)) begin
            cnt_nx = dec;
          end else if (mode) begin
            cnt_nx = rld;
            tc_nx  = 1'b1;
          end else begin
            cnt_nx   = '0;
            tc_nx    = 1'b1;
            state_nx = DONE;
          end
        end
        DONE: if (done_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign ld_ready   = (state == IDLE);
  assign busy       = (state == RUN);
  assign done_valid = (state == DONE);
endmodule

// File: tb/tb_au_dec_timer.sv
// tb/tb_au_dec_timer.sv - scoreboard bench for au_dec_timer (DIV=1 and DIV=4 instances)

module tb_au_dec_timer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       ld_valid = 0, ld_mode = 0, en = 0, abort = 0, done_ready = 0;
  logic [7:0] ld_data = 0;
  logic       ld_ready, busy, tc, done_valid;
  logic [7:0] cnt;

  logic       ld_valid_4 = 0, ld_mode_4 = 0, en_4 = 0, abort_4 = 0, done_ready_4 = 0;
  logic [7:0] ld_data_4 = 0;
  logic       ld_ready_4, busy_4, tc_4, done_valid_4;
  logic [7:0] cnt_4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         stamp;
    bit         inst;
    logic [7:0] cnt;
    logic       tc;
    logic       busy;
    logic       done;
    logic       ldr;
  } exp_t;

  exp_t q[$];
  exp_t e;

  au_dec_timer #(.WIDTH(8), .ARCH(0), .DIV(1)) u_dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_mode(ld_mode), .en(en), .abort(abort), .cnt(cnt), .busy(busy), .tc(tc),
    .done_valid(done_valid), .done_ready(done_ready)
  );

  au_dec_timer #(.WIDTH(8), .ARCH(1), .DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .ld_valid(ld_valid_4), .ld_ready(ld_ready_4), .ld_data(ld_data_4),
    .ld_mode(ld_mode_4), .en(en_4), .abort(abort_4), .cnt(cnt_4), .busy(busy_4), .tc(tc_4),
    .done_valid(done_valid_4), .done_ready(done_ready_4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the chosen instance and queue the state expected after the next edge.
  task automatic step(input bit inst, input bit lv, input logic [7:0] ld, input bit lm,
                      input bit e_in, input bit ab, input bit dr,
                      input logic [7:0] ec, input bit etc, input bit eb, input bit ed, input bit er);
    exp_t x;
    if (inst == 1'b0) begin
      ld_valid = lv; ld_data = ld; ld_mode = lm; en = e_in; abort = ab; done_ready = dr;
    end else begin
      ld_valid_4 = lv; ld_data_4 = ld; ld_mode_4 = lm; en_4 = e_in; abort_4 = ab; done_ready_4 = dr;
    end
    x.stamp = cyc + 1; x.inst = inst; x.cnt = ec; x.tc = etc; x.busy = eb; x.done = ed; x.ldr = er;
    q.push_back(x);
    @(negedge clk);
  endtask

  always begin
    @(posedge clk);
    #2;
    while (q.size() > 0 && q[0].stamp <= cyc) begin
      e = q.pop_front();
      if (e.stamp < cyc) begin
        chk($sformatf("stale@%0d", e.stamp), cyc, e.stamp);
      end else if (e.inst) begin
        chk($sformatf("cnt4@%0d", cyc), cnt_4, e.cnt);
        chk($sformatf("tc4@%0d", cyc), tc_4, e.tc);
        chk($sformatf("busy4@%0d", cyc), busy_4, e.busy);
        chk($sformatf("done4@%0d", cyc), done_valid_4, e.done);
        chk($sformatf("ldr4@%0d", cyc), ld_ready_4, e.ldr);
      end else begin
        chk($sformatf("cnt@%0d", cyc), cnt, e.cnt);
        chk($sformatf("tc@%0d", cyc), tc, e.tc);
        chk($sformatf("busy@%0d", cyc), busy, e.busy);
        chk($sformatf("done@%0d", cyc), done_valid, e.done);
        chk($sformatf("ldr@%0d", cyc), ld_ready, e.ldr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_cnt", cnt, 8'h00);
    chk("rst_ldr", ld_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tc", tc, 1'b0);
    chk("rst_done", done_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // async reset in the middle of a run
    step(0, 1, 8'h40, 0, 0, 0, 0, 8'h40, 0, 1, 0, 0);
    step(0, 0, 8'h00, 0, 0, 0, 0, 8'h40, 0, 1, 0, 0);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_cnt", cnt, 8'h00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ldr", ld_ready, 1'b1);
    chk("mid_rst_tc", tc, 1'b0);
    chk("mid_rst_done", done_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // one-shot 5, then held completion
    step(0, 1, 8'd5, 0, 1, 0, 0, 8'd5, 0, 1, 0, 0);
    for (int i = 1; i <= 5; i++)
      step(0, 0, 8'd0, 0, 1, 0, 0, 8'(5 - i), i == 5, i < 5, i == 5, 0);
    for (int i = 0; i < 3; i++)
      step(0, 0, 8'd0, 0, 1, 0, 0, 8'd0, 0, 0, 1, 0);
    step(0, 0, 8'd0, 0, 1, 0, 1, 8'd0, 0, 0, 0, 1);
    step(0, 0, 8'd0, 0, 1, 0, 0, 8'd0, 0, 0, 0, 1);

    // zero load goes straight to DONE even in auto-reload mode
    step(0, 1, 8'd0, 1, 1, 0, 0, 8'd0, 1, 0, 1, 0);
    step(0, 0, 8'd0, 0, 1, 0, 0, 8'd0, 0, 0, 1, 0);
    step(0, 0, 8'd0, 0, 1, 0, 1, 8'd0, 0, 0, 0, 1);

    // auto-reload 3 for 12 cycles, an ignored load mid-run, then abort
    step(0, 1, 8'd3, 1, 1, 0, 0, 8'd3, 0, 1, 0, 0);
    for (int i = 1; i <= 12; i++)
      step(0, i == 5, 8'h77, 0, 1, 0, 0, (i % 3 == 1) ? 8'd2 : (i % 3 == 2) ? 8'd1 : 8'd3,
           i % 3 == 0, 1, 0, 0);
    step(0, 0, 8'd0, 0, 1, 1, 0, 8'd0, 0, 0, 0, 1);
    step(0, 0, 8'd0, 0, 1, 0, 0, 8'd0, 0, 0, 0, 1);

    // DIV=4 instance: load 2, en alternating 1,0; ticks on the 4th and 8th enabled cycle
    step(1, 1, 8'd2, 0, 0, 0, 0, 8'd2, 0, 1, 0, 0);
    for (int j = 1; j <= 16; j++)
      step(1, 0, 8'd0, 0, j % 2, 0, 0, (j < 7) ? 8'd2 : (j < 15) ? 8'd1 : 8'd0,
           j == 15, j < 15, j >= 15, 0);
    step(1, 0, 8'd0, 0, 0, 0, 1, 8'd0, 0, 0, 0, 1);
    step(1, 0, 8'd0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 1);

    // all-ones load, abort together with done_ready and ld_valid, then a fresh load
    step(0, 1, 8'hFF, 0, 1, 0, 0, 8'hFF, 0, 1, 0, 0);
    for (int i = 1; i <= 10; i++)
      step(0, 0, 8'd0, 0, 1, 0, 0, 8'(8'hFF - i), 0, 1, 0, 0);
    step(0, 1, 8'd2, 0, 1, 1, 1, 8'd0, 0, 0, 0, 1);
    step(0, 1, 8'd2, 0, 1, 0, 0, 8'd2, 0, 1, 0, 0);
    step(0, 0, 8'd0, 0, 1, 0, 0, 8'd1, 0, 1, 0, 0);
    step(0, 0, 8'd0, 0, 1, 0, 0, 8'd0, 1, 0, 1, 0);
    step(0, 0, 8'd0, 0, 1, 0, 1, 8'd0, 0, 0, 0, 1);

    @(negedge clk);
    @(negedge clk);
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
